// File: rtl/fm_sb_ctrl.sv
// Spy-buffer capture/freeze/playback sequencer: drives spy memory write/read addresses and enables
// and logs one metadata word per freeze. Captured data and read data do not pass through this block.
module fm_sb_ctrl #(
    parameter int MEM_AW    = 10,
    parameter int META_AW   = 4,
    parameter int PB_MODE_W = 2
) (
    input  logic                 spy_clock,
    input  logic                 rst_n,
    input  logic [PB_MODE_W-1:0] pb_mode,
    input  logic                 arm,
    input  logic                 trigger,
    input  logic                 fm_vld,
    input  logic [MEM_AW-1:0]    post_trig_len,
    input  logic [MEM_AW-1:0]    pb_len,
    input  logic                 pb_ready,
    output logic                 mem_we,
    output logic [MEM_AW-1:0]    mem_waddr,
    output logic                 mem_re,
    output logic [MEM_AW-1:0]    mem_raddr,
    output logic                 pb_vld,
    output logic                 meta_we,
    output logic [META_AW-1:0]   meta_waddr,
    output logic [31:0]          meta_wdata,
    output logic                 frozen,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAPTURE  = 3'd1,
        ST_POST     = 3'd2,
        ST_FROZEN   = 3'd3,
        ST_PLAYBACK = 3'd4
    } state_e;

    localparam logic [MEM_AW-1:0]    MEM_ZERO    = {MEM_AW{1'b0}};
    localparam logic [MEM_AW-1:0]    MEM_ONE     = MEM_AW'(1'b1);
    localparam logic [MEM_AW-1:0]    MEM_LAST    = {MEM_AW{1'b1}};
    localparam logic [META_AW-1:0]   META_ZERO   = {META_AW{1'b0}};
    localparam logic [META_AW-1:0]   META_ONE    = META_AW'(1'b1);
    localparam logic [PB_MODE_W-1:0] MODE_FREEZE = {PB_MODE_W{1'b0}};

    // Last written address is one behind the write pointer; an untouched buffer reports 0
    function automatic logic [31:0] meta_word(input logic wrapped, input logic [MEM_AW-1:0] wr_ptr);
        logic [MEM_AW-1:0] last;
        if (!wrapped && (wr_ptr == MEM_ZERO)) begin
            last = MEM_ZERO;
        end else begin
            last = wr_ptr - MEM_ONE;
        end
        return {1'b1, wrapped, 14'd0, 16'(last)};
    endfunction

    state_e                 state_r, state_s;
    logic [PB_MODE_W-1:0]   mode_r, mode_s;
    logic [MEM_AW-1:0]      post_len_r, post_len_s;
    logic [MEM_AW-1:0]      pb_len_r, pb_len_s;
    logic [MEM_AW-1:0]      wr_ptr_r, wr_ptr_s;
    logic                   wrapped_r, wrapped_s;
    logic [MEM_AW-1:0]      rd_ptr_r, rd_ptr_s;
    logic [MEM_AW-1:0]      post_cnt_r, post_cnt_s;
    logic [META_AW-1:0]     meta_ptr_r;
    logic [MEM_AW-1:0]      pb_last_s;
    logic [31:0]            meta_wdata_s;
    logic                   mem_we_s, mem_re_s, meta_we_s;

    logic                   mem_we_r, mem_re_r, pb_vld_r, meta_we_r, frozen_r;
    logic [MEM_AW-1:0]      mem_waddr_r, mem_raddr_r;
    logic [META_AW-1:0]     meta_waddr_r;
    logic [31:0]            meta_wdata_r;

    // pb_len of 0 wraps to the all-ones address, i.e. a full-depth playback
    assign pb_last_s    = pb_len_r - MEM_ONE;
    assign meta_wdata_s = meta_word(wrapped_s, wr_ptr_s);

    // Next-state, pointer and enable decode; arm overrides everything else
    always_comb begin
        state_s    = state_r;
        mode_s     = mode_r;
        post_len_s = post_len_r;
        pb_len_s   = pb_len_r;
        wr_ptr_s   = wr_ptr_r;
        wrapped_s  = wrapped_r;
        rd_ptr_s   = rd_ptr_r;
        post_cnt_s = post_cnt_r;
        mem_we_s   = 1'b0;
        mem_re_s   = 1'b0;
        meta_we_s  = 1'b0;
        if (arm) begin
            mode_s     = pb_mode;
            post_len_s = post_trig_len;
            pb_len_s   = pb_len;
            if (pb_mode[1]) begin
                state_s  = ST_PLAYBACK;
                rd_ptr_s = MEM_ZERO;
            end else begin
                state_s   = ST_CAPTURE;
                wr_ptr_s  = MEM_ZERO;
                wrapped_s = 1'b0;
            end
        end else begin
            case (state_r)
                ST_CAPTURE: begin
                    if (fm_vld) begin
                        mem_we_s  = 1'b1;
                        wr_ptr_s  = wr_ptr_r + MEM_ONE;
                        wrapped_s = wrapped_r | (wr_ptr_r == MEM_LAST);
                    end else begin
                        mem_we_s  = 1'b0;
                    end
                    if (trigger && (mode_r == MODE_FREEZE)) begin
                        if (post_len_r == MEM_ZERO) begin
                            state_s   = ST_FROZEN;
                            meta_we_s = 1'b1;
                        end else begin
                            state_s    = ST_POST;
                            post_cnt_s = post_len_r;
                        end
                    end else begin
                        state_s = ST_CAPTURE;
                    end
                end
                ST_POST: begin
                    if (fm_vld) begin
                        mem_we_s   = 1'b1;
                        wr_ptr_s   = wr_ptr_r + MEM_ONE;
                        wrapped_s  = wrapped_r | (wr_ptr_r == MEM_LAST);
                        post_cnt_s = post_cnt_r - MEM_ONE;
                        if (post_cnt_r == MEM_ONE) begin
                            state_s   = ST_FROZEN;
                            meta_we_s = 1'b1;
                        end else begin
                            state_s = ST_POST;
                        end
                    end else begin
                        mem_we_s = 1'b0;
                    end
                end
                ST_PLAYBACK: begin
                    if (pb_ready) begin
                        mem_re_s = 1'b1;
                        if (rd_ptr_r == pb_last_s) begin
                            rd_ptr_s = MEM_ZERO;
                            if (mode_r[0]) begin
                                state_s = ST_PLAYBACK;
                            end else begin
                                state_s = ST_IDLE;
                            end
                        end else begin
                            rd_ptr_s = rd_ptr_r + MEM_ONE;
                        end
                    end else begin
                        mem_re_s = 1'b0;
                    end
                end
                ST_IDLE, ST_FROZEN: begin
                    state_s = state_r;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, pointers and all registered outputs; addresses hold between enables
    always_ff @(posedge spy_clock) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            mode_r       <= MODE_FREEZE;
            post_len_r   <= MEM_ZERO;
            pb_len_r     <= MEM_ZERO;
            wr_ptr_r     <= MEM_ZERO;
            wrapped_r    <= 1'b0;
            rd_ptr_r     <= MEM_ZERO;
            post_cnt_r   <= MEM_ZERO;
            meta_ptr_r   <= META_ZERO;
            mem_we_r     <= 1'b0;
            mem_waddr_r  <= MEM_ZERO;
            mem_re_r     <= 1'b0;
            mem_raddr_r  <= MEM_ZERO;
            pb_vld_r     <= 1'b0;
            meta_we_r    <= 1'b0;
            meta_waddr_r <= META_ZERO;
            meta_wdata_r <= 32'd0;
            frozen_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            mode_r       <= mode_s;
            post_len_r   <= post_len_s;
            pb_len_r     <= pb_len_s;
            wr_ptr_r     <= wr_ptr_s;
            wrapped_r    <= wrapped_s;
            rd_ptr_r     <= rd_ptr_s;
            post_cnt_r   <= post_cnt_s;
            meta_ptr_r   <= meta_we_s ? (meta_ptr_r + META_ONE) : meta_ptr_r;
            mem_we_r     <= mem_we_s;
            mem_waddr_r  <= mem_we_s ? wr_ptr_r : mem_waddr_r;
            mem_re_r     <= mem_re_s;
            mem_raddr_r  <= mem_re_s ? rd_ptr_r : mem_raddr_r;
            pb_vld_r     <= mem_re_r;
            meta_we_r    <= meta_we_s;
            meta_waddr_r <= meta_we_s ? meta_ptr_r : meta_waddr_r;
            meta_wdata_r <= meta_we_s ? meta_wdata_s : meta_wdata_r;
            frozen_r     <= (state_s == ST_FROZEN);
        end
    end

    assign mem_we     = mem_we_r;
    assign mem_waddr  = mem_waddr_r;
    assign mem_re     = mem_re_r;
    assign mem_raddr  = mem_raddr_r;
    assign pb_vld     = pb_vld_r;
    assign meta_we    = meta_we_r;
    assign meta_waddr = meta_waddr_r;
    assign meta_wdata = meta_wdata_r;
    assign frozen     = frozen_r;
    assign state      = state_r;

endmodule

// File: tb/tb_fm_sb_ctrl.sv
// Bench for fm_sb_ctrl (depth 16): hand-built vector table, directed corner sequences, and
// randomized traffic checked every cycle against a word-counting reference model.
module tb_fm_sb_ctrl;

    localparam int DEPTH = 16;

    logic        spy_clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pb_mode = 2'b00;
    logic        arm = 1'b0, trigger = 1'b0, fm_vld = 1'b0, pb_ready = 1'b0;
    logic [3:0]  post_trig_len = 4'd0, pb_len = 4'd0;
    logic        mem_we, mem_re, pb_vld, meta_we, frozen;
    logic [3:0]  mem_waddr, mem_raddr, meta_waddr;
    logic [31:0] meta_wdata;
    logic [2:0]  state;

    fm_sb_ctrl #(.MEM_AW(4), .META_AW(4), .PB_MODE_W(2)) dut (
        .spy_clock(spy_clock), .rst_n(rst_n), .pb_mode(pb_mode), .arm(arm),
        .trigger(trigger), .fm_vld(fm_vld), .post_trig_len(post_trig_len), .pb_len(pb_len),
        .pb_ready(pb_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_re(mem_re),
        .mem_raddr(mem_raddr), .pb_vld(pb_vld), .meta_we(meta_we), .meta_waddr(meta_waddr),
        .meta_wdata(meta_wdata), .frozen(frozen), .state(state)
    );

    always #5 spy_clock = ~spy_clock;

    int n_tot = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: tracks words written / reads issued since arm as plain counts
    int          m_st = 0, m_tw = 0, m_left = 0, m_nr = 0, m_mcnt = 0, m_plen = DEPTH, m_post = 0;
    logic [1:0]  m_mode = 2'b00;
    logic        e_we = 1'b0, e_re = 1'b0, e_vld = 1'b0, e_mwe = 1'b0;
    int          e_wa = 0, e_ra = 0, e_mwa = 0;
    logic [31:0] e_mwd = 32'd0;
    bit          freeze;

    task model_step();
        freeze = 1'b0;
        e_vld = e_re;
        e_we = 1'b0; e_re = 1'b0; e_mwe = 1'b0;
        if (!rst_n) begin
            e_vld = 1'b0; m_st = 0; m_tw = 0; m_left = 0; m_nr = 0; m_mcnt = 0;
        end else if (arm) begin
            m_mode = pb_mode;
            m_post = post_trig_len;
            m_plen = (pb_len == 4'd0) ? DEPTH : int'(pb_len);
            if (pb_mode[1]) begin m_st = 4; m_nr = 0; end
            else begin m_st = 1; m_tw = 0; end
        end else if (m_st == 1 || m_st == 2) begin
            if (fm_vld) begin e_we = 1'b1; e_wa = m_tw % DEPTH; m_tw++; end
            if (m_st == 1 && m_mode == 2'b00 && trigger) begin
                if (m_post == 0) freeze = 1'b1;
                else begin m_st = 2; m_left = m_post; end
            end else if (m_st == 2 && fm_vld) begin
                m_left--;
                if (m_left == 0) freeze = 1'b1;
            end
            if (freeze) begin
                m_st = 3; e_mwe = 1'b1; e_mwa = m_mcnt % 16; m_mcnt++;
                e_mwd = 32'h8000_0000;
                if (m_tw >= DEPTH) e_mwd[30] = 1'b1;
                if (m_tw > 0) e_mwd[15:0] = 16'((m_tw - 1) % DEPTH);
            end
        end else if (m_st == 4 && pb_ready) begin
            e_re = 1'b1; e_ra = m_nr % m_plen; m_nr++;
            if (m_mode[0] == 1'b0 && m_nr == m_plen) m_st = 0;
        end
    endtask

    task automatic cmp_model();
        chk("m_state", state, m_st);
        chk("m_frozen", frozen, (m_st == 3) ? 1 : 0);
        chk("m_mem_we", mem_we, e_we);
        if (e_we) chk("m_mem_waddr", mem_waddr, e_wa);
        chk("m_mem_re", mem_re, e_re);
        if (e_re) chk("m_mem_raddr", mem_raddr, e_ra);
        chk("m_pb_vld", pb_vld, e_vld);
        chk("m_meta_we", meta_we, e_mwe);
        if (e_mwe) begin
            chk("m_meta_waddr", meta_waddr, e_mwa);
            chk("m_meta_wdata", meta_wdata, e_mwd);
        end
    endtask

    task automatic tick();
        @(posedge spy_clock);
        model_step();
        #1;
        cmp_model();
    endtask

    task automatic drive(input logic a, input logic [1:0] m, input logic t, input logic v, input logic r);
        arm = a; pb_mode = m; trigger = t; fm_vld = v; pb_ready = r;
    endtask

    typedef struct {
        int arm, mode, trig, vld, rdy;
        int st, we, wa, re, ra, pv, mwe, mwd;
    } vec_t;
    vec_t vt[20];

    int n_meta, n_frz;

    initial begin
        vt[0]  = '{1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 1; i <= 5; i++) vt[i] = '{0, 0, 0, 1, 0,  1, 1, i - 1, 0, 0, 0, 0, 0};
        vt[6]  = '{0, 0, 1, 1, 0,  2, 1, 5, 0, 0, 0, 0, 0};
        vt[7]  = '{0, 0, 0, 1, 0,  2, 1, 6, 0, 0, 0, 0, 0};
        vt[8]  = '{0, 0, 0, 1, 0,  2, 1, 7, 0, 0, 0, 0, 0};
        vt[9]  = '{0, 0, 0, 1, 0,  3, 1, 8, 0, 0, 0, 1, 32'h8000_0008};
        vt[10] = '{0, 0, 1, 1, 0,  3, 0, 0, 0, 0, 0, 0, 0};
        vt[11] = '{0, 0, 0, 1, 0,  3, 0, 0, 0, 0, 0, 0, 0};
        vt[12] = '{1, 2, 0, 0, 0,  4, 0, 0, 0, 0, 0, 0, 0};
        vt[13] = '{0, 2, 0, 0, 1,  4, 0, 0, 1, 0, 0, 0, 0};
        vt[14] = '{0, 2, 0, 0, 0,  4, 0, 0, 0, 0, 1, 0, 0};
        vt[15] = '{0, 2, 0, 0, 1,  4, 0, 0, 1, 1, 0, 0, 0};
        vt[16] = '{0, 2, 0, 0, 1,  4, 0, 0, 1, 2, 1, 0, 0};
        vt[17] = '{0, 2, 0, 0, 1,  0, 0, 0, 1, 3, 1, 0, 0};
        vt[18] = '{0, 2, 0, 0, 1,  0, 0, 0, 0, 0, 1, 0, 0};
        vt[19] = '{0, 2, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0};

        // reset state
        tick(); tick();
        chk("rst_state", state, 0);      chk("rst_frozen", frozen, 0);
        chk("rst_mem_we", mem_we, 0);    chk("rst_mem_waddr", mem_waddr, 0);
        chk("rst_mem_re", mem_re, 0);    chk("rst_mem_raddr", mem_raddr, 0);
        chk("rst_pb_vld", pb_vld, 0);    chk("rst_meta_we", meta_we, 0);
        chk("rst_meta_waddr", meta_waddr, 0); chk("rst_meta_wdata", meta_wdata, 0);

        // capture/freeze with post_trig_len=3, then playback once with pb_len=4
        rst_n = 1'b1; post_trig_len = 4'd3; pb_len = 4'd4;
        for (int i = 0; i < 20; i++) begin
            drive(vt[i].arm[0], vt[i].mode[1:0], vt[i].trig[0], vt[i].vld[0], vt[i].rdy[0]);
            tick();
            chk("tbl_state", state, vt[i].st);
            chk("tbl_frozen", frozen, (vt[i].st == 3) ? 1 : 0);
            chk("tbl_mem_we", mem_we, vt[i].we);
            if (vt[i].we != 0) chk("tbl_mem_waddr", mem_waddr, vt[i].wa);
            chk("tbl_mem_re", mem_re, vt[i].re);
            if (vt[i].re != 0) chk("tbl_mem_raddr", mem_raddr, vt[i].ra);
            chk("tbl_pb_vld", pb_vld, vt[i].pv);
            chk("tbl_meta_we", meta_we, vt[i].mwe);
            if (vt[i].mwe != 0) begin
                chk("tbl_meta_wdata", meta_wdata, vt[i].mwd);
                chk("tbl_meta_waddr", meta_waddr, 0);
            end
        end

        // wrapped capture, trigger with zero post length and no word
        post_trig_len = 4'd0;
        drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0); tick();
        repeat (20) begin drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0); tick(); end
        drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0); tick();
        chk("t2_state", state, 3);
        chk("t2_meta_we", meta_we, 1);
        chk("t2_meta_wdata", meta_wdata, 32'hC000_0003);
        chk("t2_meta_waddr", meta_waddr, 1);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0); tick();
        chk("t2_meta_pulse", meta_we, 0);

        // free-run capture ignores triggers
        drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0); tick();
        n_meta = 0; n_frz = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 2'b01, (i % 3) == 0, 1'b1, 1'b0); tick();
            if (meta_we) n_meta++;
            if (frozen) n_frz++;
            chk("t3_waddr", mem_waddr, i % 16);
        end
        chk("t3_no_meta", n_meta, 0);
        chk("t3_never_frozen", n_frz, 0);

        // playback loop, full depth
        pb_len = 4'd0;
        drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b1); tick();
            chk("t4_raddr", mem_raddr, i % 16);
        end
        chk("t4_state", state, 4);

        // arm coincident with trigger while in POST restarts capture
        post_trig_len = 4'd2;
        drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, 2'b00, 1'b1, 1'b1, 1'b0); tick();
        drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0); tick();
        chk("t5_in_post", state, 2);
        drive(1'b1, 2'b00, 1'b1, 1'b1, 1'b0); tick();
        chk("t5_restart_state", state, 1);
        chk("t5_restart_nowrite", mem_we, 0);
        drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0); tick();
        chk("t5_waddr0", mem_waddr, 0);
        drive(1'b0, 2'b00, 1'b1, 1'b1, 1'b0); tick();
        drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b0); tick();
        chk("t5_frozen", state, 3);
        chk("t5_meta_wdata", meta_wdata, 32'h8000_0003);
        chk("t5_meta_waddr", meta_waddr, 2);

        // reset with a read outstanding
        pb_len = 4'd5;
        drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0); tick();
        repeat (3) begin drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b1); tick(); end
        chk("t6_re_before", mem_re, 1);
        rst_n = 1'b0; tick();
        chk("t6_state", state, 0);   chk("t6_mem_re", mem_re, 0);
        chk("t6_pb_vld", pb_vld, 0); chk("t6_raddr", mem_raddr, 0);
        chk("t6_mem_we", mem_we, 0); chk("t6_meta_we", meta_we, 0);
        rst_n = 1'b1; tick();
        chk("t6_pb_vld_after", pb_vld, 0);
        chk("t6_idle_after", state, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom_range(0, 299) != 0);
            post_trig_len = 4'($urandom_range(0, 6));
            pb_len        = 4'($urandom_range(0, 6));
            drive($urandom_range(0, 24) == 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
